// File: rtl/history_pkg.sv
// Shared defaults and FSM state type for the history buffer and its fetch engine.
// HISTORY_FETCH_CHECKSUM_EN adds the CSUM state used for the trailing XOR byte.
package history_pkg;

  localparam int HIST_DEPTH      = 256;
  localparam int HIST_ADDR_WIDTH = 8;

`ifdef HISTORY_FETCH_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CSUM  = 2'd3
  } history_fetch_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } history_fetch_state_t;
`endif

endpackage

// File: rtl/history_fetch_fifo.sv
// 4-entry output FIFO for history_fetch: 8-bit byte plus a final-byte marker.
// Head outputs read as zero while empty.
module history_fetch_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       push_last,
  input  logic       pop,
  output logic [2:0] count,
  output logic       valid,
  output logic [7:0] head_data,
  output logic       head_last
);

  logic [8:0] mem_q [4];
  logic [8:0] mem_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       do_push, do_pop;

  assign do_pop  = pop & (count_q != 3'd0);
  assign do_push = push & (count_q != 3'd4);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = {push_last, push_data};
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    count_d = count_q + {2'b00, do_push} - {2'b00, do_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count     = count_q;
  assign valid     = (count_q != 3'd0);
  assign head_data = valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
  assign head_last = valid ? mem_q[rd_ptr_q][8] : 1'b0;

endmodule

// File: rtl/history_fetch.sv
// Replays a window of the history buffer oldest-first on a valid/ready byte stream.
// HISTORY_FETCH_CHECKSUM_EN appends an XOR checksum byte carrying out_last.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; zero-length and out-of-range rejected here
// ST_FETCH | issuing buffer reads, oldest index first, gated by FIFO credit
// ST_DRAIN | all reads issued; streaming out until the final data byte
// ST_CSUM  | presenting the checksum byte (checksum build only)
module history_fetch
  import history_pkg::*;
#(
  parameter int DEPTH      = HIST_DEPTH,
  parameter int ADDR_WIDTH = HIST_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_offset,
  input  logic [ADDR_WIDTH:0]   start_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  buf_read_en,
  output logic [ADDR_WIDTH-1:0] buf_read_index,
  input  logic [7:0]            buf_read_data,
  input  logic [ADDR_WIDTH:0]   buf_count,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic                  out_last,
  input  logic                  out_ready
);

  localparam int LW = ADDR_WIDTH + 1;

  history_fetch_state_t  state_q, state_d;
  logic [ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         rd_cnt_q, rd_cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
`ifdef HISTORY_FETCH_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic [2:0]            fifo_count;
  logic                  fifo_valid, fifo_last, fifo_pop;
  logic [7:0]            fifo_data;
  logic                  credit_ok, rd_en, final_rd, last_hs, reject;
  logic [ADDR_WIDTH+1:0] need_w;
  logic [ADDR_WIDTH-1:0] rd_idx;

  // Window end is computed wide so offset+len never wraps against buf_count.
  assign need_w = {2'b00, start_offset} + {1'b0, start_len};
  assign reject = (need_w > {1'b0, buf_count}) || (start_len > LW'(DEPTH));

  // At most two bytes committed (queued or returning) keeps the 4-deep FIFO safe.
  assign credit_ok = ({1'b0, fifo_count} + {3'b000, inflight_q}) <= 4'd2;
  assign rd_en     = (state_q == ST_FETCH) && credit_ok;
  assign final_rd  = (rd_cnt_q + LW'(1)) == len_q;
  assign rd_idx    = offset_q + len_q[ADDR_WIDTH-1:0] - rd_cnt_q[ADDR_WIDTH-1:0]
                     - ADDR_WIDTH'(1);

  assign fifo_pop = fifo_valid & out_ready;
  assign last_hs  = fifo_pop & fifo_last;

  always_comb begin
    state_d         = state_q;
    offset_d        = offset_q;
    len_d           = len_q;
    rd_cnt_d        = rd_cnt_q;
    inflight_d      = rd_en;
    inflight_last_d = rd_en & final_rd;
    done_d          = 1'b0;
    err_d           = 1'b0;
`ifdef HISTORY_FETCH_CHECKSUM_EN
    csum_d          = fifo_pop ? (csum_q ^ fifo_data) : csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          offset_d = start_offset;
          len_d    = start_len;
          rd_cnt_d = '0;
`ifdef HISTORY_FETCH_CHECKSUM_EN
          csum_d   = 8'h00;
`endif
          if (start_len == '0) begin
            done_d = 1'b1;
          end else if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (rd_en) begin
          rd_cnt_d = rd_cnt_q + LW'(1);
          if (final_rd) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_hs) begin
`ifdef HISTORY_FETCH_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef HISTORY_FETCH_CHECKSUM_EN
      ST_CSUM: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      offset_q        <= '0;
      len_q           <= '0;
      rd_cnt_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
`ifdef HISTORY_FETCH_CHECKSUM_EN
      csum_q          <= 8'h00;
`endif
    end else begin
      state_q         <= state_d;
      offset_q        <= offset_d;
      len_q           <= len_d;
      rd_cnt_q        <= rd_cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
      err_q           <= err_d;
`ifdef HISTORY_FETCH_CHECKSUM_EN
      csum_q          <= csum_d;
`endif
    end
  end

  history_fetch_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (buf_read_data),
    .push_last (inflight_last_q),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .valid     (fifo_valid),
    .head_data (fifo_data),
    .head_last (fifo_last)
  );

  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign err            = err_q;
  assign buf_read_en    = rd_en;
  assign buf_read_index = rd_en ? rd_idx : '0;

`ifdef HISTORY_FETCH_CHECKSUM_EN
  assign out_valid = fifo_valid | (state_q == ST_CSUM);
  assign out_data  = (state_q == ST_CSUM) ? csum_q : fifo_data;
  assign out_last  = (state_q == ST_CSUM);
`else
  assign out_valid = fifo_valid;
  assign out_data  = fifo_data;
  assign out_last  = fifo_last;
`endif

endmodule

// File: tb/tb_history_fetch.sv
// Bench for history_fetch: command table plus reset and busy-start sequences,
// against a buffer model prefilled with 0x10..0x19 (newest 0x19).
module tb_history_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] start_offset;
  logic [8:0] start_len;
  logic       busy, done, err;
  logic       buf_read_en;
  logic [7:0] buf_read_index;
  logic [7:0] buf_read_data;
  logic [8:0] buf_count;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;
  logic       buf_write_en;

  history_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_offset   (start_offset),
    .start_len      (start_len),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .buf_read_en    (buf_read_en),
    .buf_read_index (buf_read_index),
    .buf_read_data  (buf_read_data),
    .buf_count      (buf_count),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int offset;
    int len;
    int ready_mode;  // 0 always, 1 toggle, 2 random
    int kind;        // expected: 0 stream, 1 zero-length done, 2 err
    int glitch;      // 1: pulse a second start while busy
  } vec_t;

  logic [7:0] hist [256];
  logic [8:0] exp_q [$];
  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  int ready_mode = 0;
  int rd_seen, valid_seen, done_seen, err_seen, hs_count;
  int first_valid_cyc, last_hs_cyc, done_cyc;
  logic done_busy;
  logic prev_pending;
  logic [8:0] prev_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Buffer read port: data one cycle after read_en, writes never enabled.
  always @(posedge clk) begin
    if (buf_read_en) buf_read_data <= hist[buf_read_index];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && busy) assert (!buf_write_en) else $error("buffer write while busy");
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard pop.
  always @(negedge clk) begin
    if (rst) begin
      prev_pending = 1'b0;
    end else begin
      if (buf_read_en) rd_seen++;
      if (out_valid) begin
        valid_seen++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (done) begin
        done_seen++;
        done_cyc  = cyc;
        done_busy = busy;
      end
      if (err) err_seen++;
      if (prev_pending) check("stable", {out_valid, out_last, out_data}, {1'b1, prev_word});
      if (out_valid && out_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", {out_last, out_data});
        end else begin
          check("stream", {out_last, out_data}, exp_q.pop_front());
        end
        if (out_last) last_hs_cyc = cyc;
        prev_pending = 1'b0;
      end else if (out_valid) begin
        prev_pending = 1'b1;
        prev_word    = {out_last, out_data};
      end else begin
        prev_pending = 1'b0;
      end
    end
  end

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic clear_counters();
    rd_seen = 0; valid_seen = 0; done_seen = 0; err_seen = 0; hs_count = 0;
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1; done_busy = 1'b1;
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int t1, waited;
    logic [7:0] x, b;
    x = 8'h00;
    if (v.kind == 0) begin
      for (int i = 0; i < v.len; i++) begin
        b = hist[v.offset + v.len - 1 - i];
        x = x ^ b;
`ifdef HISTORY_FETCH_CHECKSUM_EN
        exp_q.push_back({1'b0, b});
`else
        exp_q.push_back({(i == v.len - 1), b});
`endif
      end
`ifdef HISTORY_FETCH_CHECKSUM_EN
      exp_q.push_back({1'b1, x});
`endif
    end
    clear_counters();
    ready_mode = v.ready_mode;
    @(posedge clk); #1;
    start = 1'b1; start_offset = v.offset[7:0]; start_len = v.len[8:0];
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    t1 = cyc;
    case (v.kind)
      0: check({tag, "_t1"}, {busy, buf_read_en, done, err}, 4'b1100);
      1: check({tag, "_t1"}, {busy, buf_read_en, done, err}, 4'b0010);
      default: check({tag, "_t1"}, {busy, buf_read_en, done, err}, 4'b0001);
    endcase
    if (v.kind == 0) begin
      if (v.glitch != 0) begin
        @(posedge clk); #1;
        start = 1'b1; start_offset = 8'd5; start_len = 9'd2;
        @(posedge clk); #1;
        start = 1'b0;
      end
      waited = 0;
      while (done_seen == 0 && waited < 2000) begin
        sample();
        waited++;
      end
      check({tag, "_done"}, done_seen, 1);
      check({tag, "_done_lat"}, done_cyc - last_hs_cyc, 1);
      check({tag, "_done_busy"}, {31'd0, done_busy}, 0);
      check({tag, "_first_valid"}, first_valid_cyc - t1, 2);
    end else begin
      repeat (4) sample();
      check({tag, "_no_valid"}, valid_seen, 0);
    end
    repeat (4) sample();
    check({tag, "_reads"}, rd_seen, (v.kind == 0) ? v.len : 0);
    check({tag, "_leftover"}, exp_q.size(), 0);
    check({tag, "_done_cnt"}, done_seen, (v.kind == 2) ? 0 : 1);
    check({tag, "_err_cnt"}, err_seen, (v.kind == 2) ? 1 : 0);
    check({tag, "_idle"}, {31'd0, busy}, 0);
    exp_q.delete();
  endtask

  vec_t vecs [11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{0, 3, 0, 0, 0};
    vecs[1]  = '{2, 4, 1, 0, 0};
    vecs[2]  = '{0, 0, 0, 1, 0};
    vecs[3]  = '{8, 3, 0, 2, 0};
    vecs[4]  = '{0, 10, 2, 0, 0};
    vecs[5]  = '{9, 1, 1, 0, 0};
    vecs[6]  = '{0, 11, 0, 2, 0};
    vecs[7]  = '{10, 0, 0, 1, 0};
    vecs[8]  = '{3, 7, 2, 0, 0};
    vecs[9]  = '{0, 3, 1, 0, 1};
    vecs[10] = '{4, 6, 0, 0, 0};

    for (int i = 0; i < 256; i++) hist[i] = 8'hEE;
    for (int i = 0; i < 10; i++) hist[i] = 8'h19 - 8'(i);
    buf_count    = 9'd10;
    buf_write_en = 1'b0;
    start        = 1'b0;
    start_offset = 8'd0;
    start_len    = 9'd0;
    clear_counters();
    rst = 1'b1;
    repeat (3) sample();
    check("reset_outputs",
          {busy, done, err, buf_read_en, buf_read_index, out_valid, out_data, out_last}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) sample();

    for (int i = 0; i < 11; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Reset after two of five bytes accepted.
    for (int i = 0; i < 5; i++) begin
`ifdef HISTORY_FETCH_CHECKSUM_EN
      exp_q.push_back({1'b0, hist[4 - i]});
`else
      exp_q.push_back({(i == 4), hist[4 - i]});
`endif
    end
    clear_counters();
    ready_mode = 0;
    @(posedge clk); #1;
    start = 1'b1; start_offset = 8'd0; start_len = 9'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int w = 0; w < 50 && hs_count < 2; w++) sample();
    check("rst_hs_before", hs_count, 2);
    ready_mode = 3;
    @(posedge clk); #1;
    rst = 1'b1;
    sample();
    check("rst_outputs",
          {busy, done, err, buf_read_en, buf_read_index, out_valid, out_data, out_last}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) sample();
    check("rst_no_done", done_seen, 0);
    check("rst_dropped", exp_q.size(), 3);
    exp_q.delete();
    run_cmd('{0, 2, 0, 0, 0}, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
